bmem_line_adapter: RTL and testbench
====================================

# bmem_line_adapter

Converts one 256-bit cache-line request into the burst-memory beat protocol, and turns returned beats back into a line response. Sits directly downstream of the four-cache round-robin arbiter in the memory subsystem:
- The arbiter presents one line read or write at a time.
- This block owns all bmem beat sequencing, backpressure and read-data assembly.
- The arbiter only sees a single-cycle request/response handshake.

## Interface
Parameters:
- BEATS, 4, beats per line; must be a power of two ≥ 2.
- BEAT_W, 64, bits per beat; line width is BEATS*BEAT_W (256).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  line request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = line write, 0 = line read.
- req_addr  in  32  line address; bits [4:0] are ignored and forced to zero.
- req_wdata  in  256  write line; beat i = bits [64i+63:64i].
- resp_valid  out  1  one-cycle completion pulse for both reads and writes.
- resp_rdata  out  256  assembled read line; zero for writes.
- resp_raddr  out  32  aligned address of the completed line.
- bmem_addr  out  32  aligned line address; zero when idle.
- bmem_read  out  1  read command.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  64  current write beat.
- bmem_ready  in  1  memory accepts a command or beat this cycle.
- bmem_raddr  in  32  address tag of a returning beat.
- bmem_rdata  in  64  returning beat data.
- bmem_rvalid  in  1  returning beat valid.

## Operation
- States: IDLE, RD_CMD, RD_WAIT, WR_BURST, RESP.
- IDLE:
  - req_valid && req_ready latches addr (with [4:0]=0), write flag and wdata.
  - Next state is WR_BURST if req_write, else RD_CMD.
- RD_CMD:
  - Drives bmem_read=1 and bmem_addr=latched address.
  - Leaves for RD_WAIT only on a cycle with bmem_ready=1; holds otherwise.
- RD_WAIT:
  - Counts beats where bmem_rvalid=1 and bmem_raddr[31:5] equals the latched [31:5].
  - Beat k is stored into line bits [64k+63:64k].
  - Mismatched or out-of-state rvalid beats are dropped and do not advance the counter.
  - After beat BEATS-1 is captured, goes to RESP.
- WR_BURST:
  - Drives bmem_write=1, bmem_addr=latched address, bmem_wdata=beat[cnt].
  - cnt advances only when bmem_ready=1.
  - With ready low, the beat and bmem_write are held unchanged.
  - After beat BEATS-1 is accepted, goes to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_raddr=latched address.
  - resp_rdata=assembled line for reads, 0 for writes.
  - Returns to IDLE.
- Beat counter width is log2(BEATS); it wraps to 0 on leaving RD_WAIT/WR_BURST.
- rvalid arriving in RESP or IDLE is ignored; no buffering.
- Reset at any point:
  - state=IDLE, counter=0, line buffers=0, all outputs 0.
  - No response is produced for the aborted request.

## Timing
- Reset values: req_ready=0 during the reset cycle, 1 on the first cycle after; every other output 0.
- Read, with request accepted at edge 0 and bmem_ready=1:
  - bmem_read is high in cycle 1 only.
  - resp_valid fires in the cycle after the edge that captures the final beat.
  - Minimum read latency is 1 + memory latency + BEATS cycles.
- Write, with bmem_ready held high:
  - bmem_write is high in cycles 1..4.
  - resp_valid fires in cycle 5.
  - Each low-ready cycle adds one cycle.
- bmem_read is never high for more than one accepted cycle per request.
- bmem_read and bmem_write are never both high.
- req_ready is low from the acceptance edge until the cycle after resp_valid.
- Back-to-back: the next request is accepted no earlier than the cycle after RESP.

## Structure
- Shared package `bmem_pkg` holds:
  - BEATS, BEAT_W, LINE_W constants.
  - The `bmem_adapter_state_t` enum.
- One sub-module, `line_beat_collector`:
  - Tag compare, beat counter and 256-bit assembly register for the read path.
  - Outputs `line_done` and `line_data`.
- The write serializer stays inline.

## Test plan
- Read, ready=1, memory returns 4 tagged beats 0x11..,0x22..,0x33..,0x44.. at addr 0x0000_1040 -> bmem_addr=0x0000_1040 for one cycle; resp_rdata={0x44..,0x33..,0x22..,0x11..}; resp_raddr=0x0000_1040; resp_valid for one cycle.
- Write of 0xAAAA..(beat0)..0xDDDD..(beat3) to addr 0x0000_2017, ready=1 -> bmem_addr=0x0000_2000; beats A,B,C,D on cycles 1–4; resp_valid on cycle 5; resp_rdata=0.
- Write with bmem_ready low on cycle 2 only -> beat B held two cycles; 5 bmem_write-high cycles total; resp_valid on cycle 6.
- Read, bmem_ready low for 3 cycles in RD_CMD -> bmem_read stays high 4 cycles; exactly one read is accepted; response is correct.
- Read with a stray beat tagged 0x0000_3000 interleaved before beat 2 -> stray beat ignored; line is assembled correctly from the 4 matching beats.
- rst asserted after 2 write beats -> next cycle all outputs 0, req_ready=1; no resp_valid; a new read then completes normally.

Source files
------------

// File: rtl/bmem_pkg.sv
// Shared constants and state encoding for the burst-memory line adapter.
// Default geometry: four 64-bit beats per 256-bit cache line, 32-bit byte addresses.
package bmem_pkg;

   localparam int BEATS    = 4;
   localparam int BEAT_W   = 64;
   localparam int LINE_W   = BEATS * BEAT_W;
   localparam int ADDR_W   = 32;
   localparam int OFFSET_W = 5;
   localparam int TAG_W    = ADDR_W - OFFSET_W;

   // Fixed encodings, kept so older tools and waveform filters still match.
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RD_CMD   = 3'd1;
   localparam logic [2:0] S_RD_WAIT  = 3'd2;
   localparam logic [2:0] S_WR_BURST = 3'd3;
   localparam logic [2:0] S_RESP     = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE     = S_IDLE,
      ST_RD_CMD   = S_RD_CMD,
      ST_RD_WAIT  = S_RD_WAIT,
      ST_WR_BURST = S_WR_BURST,
      ST_RESP     = S_RESP
   } bmem_adapter_state_t;

endpackage

// File: rtl/line_beat_collector.sv
// Read-path helper: accepts returning beats whose line tag matches the
// outstanding request and packs them, in arrival order, into one line.
module line_beat_collector
   import bmem_pkg::*;
#(
   parameter int BEATS_P  = bmem_pkg::BEATS,
   parameter int BEAT_W_P = bmem_pkg::BEAT_W,
   parameter int TAG_W_P  = bmem_pkg::TAG_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic [TAG_W_P-1:0]           tag_ref,
   input  logic [TAG_W_P-1:0]           beat_tag,
   input  logic [BEAT_W_P-1:0]          beat_data,
   input  logic                         beat_valid,
   output logic                         line_done,
   output logic [BEATS_P*BEAT_W_P-1:0]  line_data
);

   localparam int CNT_W = $clog2(BEATS_P);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_P - 1);

   logic [CNT_W-1:0]    cnt;
   logic [BEAT_W_P-1:0] beat_q [BEATS_P];
   logic                hit;

   // A beat counts only while waiting for data and only if it belongs to our line.
   always_comb begin
      hit       = enable && beat_valid && (beat_tag == tag_ref);
      line_done = hit && (cnt == LAST_BEAT);
   end

   // Store each matching beat in the next slot; the counter wraps to zero after the last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         for (int i = 0; i < BEATS_P; i++) begin
            beat_q[i] <= '0;
         end
      end else if (hit) begin
         beat_q[cnt] <= beat_data;
         cnt         <= cnt + CNT_W'(1);
      end
   end

   // Flatten the beat slots so beat k lands in bits [k*BEAT_W +: BEAT_W].
   always_comb begin
      line_data = '0;
      for (int i = 0; i < BEATS_P; i++) begin
         line_data[i*BEAT_W_P +: BEAT_W_P] = beat_q[i];
      end
   end

endmodule

// File: rtl/bmem_line_adapter.sv
// Turns single-cycle cache-line requests from the arbiter into burst-memory
// beat traffic, and folds returning read beats back into a line response.
module bmem_line_adapter #(
   parameter int BEATS  = bmem_pkg::BEATS,
   parameter int BEAT_W = bmem_pkg::BEAT_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [31:0]               req_addr,
   input  logic [BEATS*BEAT_W-1:0]   req_wdata,
   output logic                      resp_valid,
   output logic [BEATS*BEAT_W-1:0]   resp_rdata,
   output logic [31:0]               resp_raddr,
   output logic [31:0]               bmem_addr,
   output logic                      bmem_read,
   output logic                      bmem_write,
   output logic [BEAT_W-1:0]         bmem_wdata,
   input  logic                      bmem_ready,
   input  logic [31:0]               bmem_raddr,
   input  logic [BEAT_W-1:0]         bmem_rdata,
   input  logic                      bmem_rvalid
);

   import bmem_pkg::*;

   localparam int LINE_BITS = BEATS * BEAT_W;
   localparam int CNT_W     = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   bmem_adapter_state_t state;
   logic [TAG_W-1:0]    tag_q;
   logic                write_q;
   logic [CNT_W-1:0]    wr_cnt;
   logic [BEAT_W-1:0]   wbeat_q [BEATS];
   logic [31:0]         line_addr;
   logic                line_done;
   logic [LINE_BITS-1:0] line_data;
   logic                unused_low_bits;

   // Byte-offset bits of both addresses are irrelevant at line granularity.
   assign unused_low_bits = ^{req_addr[OFFSET_W-1:0], bmem_raddr[OFFSET_W-1:0]};
   assign line_addr       = {tag_q, OFFSET_W'(0)};

   line_beat_collector #(
      .BEATS_P  (BEATS),
      .BEAT_W_P (BEAT_W),
      .TAG_W_P  (TAG_W)
   ) u_collector (
      .clk        (clk),
      .rst        (rst),
      .enable     (state == ST_RD_WAIT),
      .tag_ref    (tag_q),
      .beat_tag   (bmem_raddr[ADDR_W-1:OFFSET_W]),
      .beat_data  (bmem_rdata),
      .beat_valid (bmem_rvalid),
      .line_done  (line_done),
      .line_data  (line_data)
   );

   // Request capture, write serializer and state sequencing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         tag_q   <= '0;
         write_q <= 1'b0;
         wr_cnt  <= '0;
         for (int i = 0; i < BEATS; i++) begin
            wbeat_q[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  tag_q   <= req_addr[ADDR_W-1:OFFSET_W];
                  write_q <= req_write;
                  for (int i = 0; i < BEATS; i++) begin
                     wbeat_q[i] <= req_wdata[i*BEAT_W +: BEAT_W];
                  end
                  state <= req_write ? ST_WR_BURST : ST_RD_CMD;
               end
            end
            ST_RD_CMD: begin
               if (bmem_ready) begin
                  state <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               if (line_done) begin
                  state <= ST_RESP;
               end
            end
            ST_WR_BURST: begin
               if (bmem_ready) begin
                  wr_cnt <= wr_cnt + CNT_W'(1);
                  if (wr_cnt == LAST_BEAT) begin
                     state <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from the state so every bus is quiet outside its own phase.
   always_comb begin
      req_ready  = (state == ST_IDLE) && !rst;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_raddr = '0;
      bmem_addr  = '0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_wdata = '0;
      case (state)
         ST_RD_CMD: begin
            bmem_read = 1'b1;
            bmem_addr = line_addr;
         end
         ST_WR_BURST: begin
            bmem_write = 1'b1;
            bmem_addr  = line_addr;
            bmem_wdata = wbeat_q[wr_cnt];
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_raddr = line_addr;
            resp_rdata = write_q ? '0 : line_data;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Self-checking bench for bmem_line_adapter: directed scenarios followed by
// randomized reads and writes, checked against a transaction-level model.
module tb_bmem_line_adapter;

   localparam int NB = 4;
   localparam int BW = 64;
   localparam int LW = NB * BW;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [31:0]   req_addr;
   logic [LW-1:0] req_wdata;
   logic          resp_valid;
   logic [LW-1:0] resp_rdata;
   logic [31:0]   resp_raddr;
   logic [31:0]   bmem_addr;
   logic          bmem_read;
   logic          bmem_write;
   logic [BW-1:0] bmem_wdata;
   logic          bmem_ready;
   logic [31:0]   bmem_raddr;
   logic [BW-1:0] bmem_rdata;
   logic          bmem_rvalid;

   int checks = 0;
   int errors = 0;

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   bmem_line_adapter #(.BEATS(NB), .BEAT_W(BW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_raddr  (resp_raddr),
      .bmem_addr   (bmem_addr),
      .bmem_read   (bmem_read),
      .bmem_write  (bmem_write),
      .bmem_wdata  (bmem_wdata),
      .bmem_ready  (bmem_ready),
      .bmem_raddr  (bmem_raddr),
      .bmem_rdata  (bmem_rdata),
      .bmem_rvalid (bmem_rvalid)
   );

   // Safety net so a wedged run still ends with a visible failure.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkBus(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [BW-1:0] wd, input logic rv, input logic rr);
      checkOutput({tag, "_bmem_read"}, bmem_read, rd);
      checkOutput({tag, "_bmem_write"}, bmem_write, wr);
      checkOutput({tag, "_bmem_addr"}, bmem_addr, addr);
      checkOutput({tag, "_bmem_wdata"}, bmem_wdata, wd);
      checkOutput({tag, "_resp_valid"}, resp_valid, rv);
      checkOutput({tag, "_req_ready"}, req_ready, rr);
   endtask

   task automatic applyStimulus(input logic valid, input logic write, input logic [31:0] addr, input logic [LW-1:0] wdata);
      req_valid = valid;
      req_write = write;
      req_addr  = addr;
      req_wdata = wdata;
   endtask

   function automatic logic [LW-1:0] rand256();
      logic [LW-1:0] r;
      for (int i = 0; i < LW / 32; i++) begin
         r[i*32 +: 32] = $urandom;
      end
      return r;
   endfunction

   // Line write: beats leave in order 0..NB-1, one per ready cycle; stallMask bit j
   // drops ready in burst cycle j+1. Response is due in cycle 1 + NB + stalls.
   task automatic doWrite(input string tag, input logic [31:0] addr, input logic [LW-1:0] line, input logic [3:0] stallMask);
      logic [31:0] al;
      int k;
      int c;
      int expCycle;
      al       = {addr[31:5], 5'b0};
      expCycle = 1 + NB + $countones(stallMask);
      checkOutput({tag, "_accept_ready"}, req_ready, 1'b1);
      applyStimulus(1'b1, 1'b1, addr, line);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, '0);
      k = 0;
      c = 1;
      while (k < NB && c <= 16) begin
         checkBus({tag, "_beat"}, 1'b0, 1'b1, al, line[k*BW +: BW], 1'b0, 1'b0);
         bmem_ready  = (c <= 4) ? !stallMask[c-1] : 1'b1;
         bmem_rvalid = $urandom_range(0, 1);
         bmem_raddr  = al;
         bmem_rdata  = {$urandom, $urandom};
         tick();
         if (bmem_ready) k++;
         c++;
      end
      bmem_ready  = 1'b0;
      bmem_rvalid = 1'b0;
      checkOutput({tag, "_resp_cycle"}, c, expCycle);
      checkBus({tag, "_resp"}, 1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0);
      checkOutput({tag, "_resp_rdata"}, resp_rdata, '0);
      checkOutput({tag, "_resp_raddr"}, resp_raddr, al);
      tick();
      checkBus({tag, "_after"}, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b1);
   endtask

   // Line read: command held for cmdStalls not-ready cycles, then memLat quiet cycles,
   // then NB tagged beats, each optionally preceded by a stray beat from strayAddr.
   // Beats also arrive during the command phase, the response and idle to prove they are ignored.
   task automatic doRead(input string tag, input logic [31:0] addr, input int cmdStalls, input int memLat,
                         input logic [3:0] strayMask, input logic [31:0] strayAddr, input logic [LW-1:0] line);
      logic [31:0] al;
      int readHigh;
      al       = {addr[31:5], 5'b0};
      readHigh = 0;
      checkOutput({tag, "_accept_ready"}, req_ready, 1'b1);
      applyStimulus(1'b1, 1'b0, addr, rand256());
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, '0);
      for (int i = 0; i <= cmdStalls; i++) begin
         checkBus({tag, "_cmd"}, 1'b1, 1'b0, al, '0, 1'b0, 1'b0);
         if (bmem_read) readHigh++;
         bmem_ready  = (i == cmdStalls);
         bmem_rvalid = 1'b1;
         bmem_raddr  = al;
         bmem_rdata  = {$urandom, $urandom};
         tick();
      end
      bmem_rvalid = 1'b0;
      checkOutput({tag, "_read_high_cycles"}, readHigh, cmdStalls + 1);
      for (int i = 0; i < memLat; i++) begin
         checkBus({tag, "_lat"}, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0);
         bmem_ready = $urandom_range(0, 1);
         tick();
      end
      for (int k = 0; k < NB; k++) begin
         if (strayMask[k]) begin
            checkBus({tag, "_stray"}, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0);
            bmem_rvalid = 1'b1;
            bmem_raddr  = strayAddr;
            bmem_rdata  = {$urandom, $urandom};
            tick();
         end
         checkBus({tag, "_data"}, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0);
         bmem_rvalid = 1'b1;
         bmem_raddr  = al | 32'($urandom_range(0, 31));
         bmem_rdata  = line[k*BW +: BW];
         tick();
      end
      checkBus({tag, "_resp"}, 1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0);
      checkOutput({tag, "_resp_rdata"}, resp_rdata, line);
      checkOutput({tag, "_resp_raddr"}, resp_raddr, al);
      bmem_raddr = al;
      bmem_rdata = {$urandom, $urandom};
      tick();
      checkBus({tag, "_after"}, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b1);
      checkOutput({tag, "_after_rdata"}, resp_rdata, '0);
      tick();
      bmem_rvalid = 1'b0;
      checkBus({tag, "_idle"}, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b1);
   endtask

   // Directed scenarios first, then a randomized mix of reads and writes.
   initial begin
      logic [LW-1:0] line;
      logic [31:0]   addr;
      logic [31:0]   al;
      logic [26:0]   delta;

      rst         = 1'b1;
      bmem_ready  = 1'b0;
      bmem_raddr  = '0;
      bmem_rdata  = '0;
      bmem_rvalid = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, '0);
      tick();
      tick();
      checkOutput("reset_req_ready", req_ready, 1'b0);
      checkBus("reset", 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0);
      checkOutput("reset_resp_rdata", resp_rdata, '0);
      checkOutput("reset_resp_raddr", resp_raddr, 32'h0);
      rst = 1'b0;
      #1;
      checkOutput("post_reset_req_ready", req_ready, 1'b1);
      tick();

      line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      doRead("rd_basic", 32'h0000_1040, 0, 2, 4'b0000, 32'h0, line);

      line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
      doWrite("wr_basic", 32'h0000_2017, line, 4'b0000);
      doWrite("wr_stall2", 32'h0000_2017, line, 4'b0010);

      doRead("rd_cmd_stall", 32'h0000_1040, 3, 1, 4'b0000, 32'h0, rand256());
      line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      doRead("rd_stray", 32'h0000_1040, 0, 0, 4'b0100, 32'h0000_3000, line);

      // Abort a write after two accepted beats.
      line = rand256();
      checkOutput("abort_accept_ready", req_ready, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h0000_5000, line);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, '0);
      bmem_ready = 1'b1;
      tick();
      tick();
      checkBus("abort_pre", 1'b0, 1'b1, 32'h0000_5000, line[2*BW +: BW], 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("abort_rst_req_ready", req_ready, 1'b0);
      tick();
      rst        = 1'b0;
      bmem_ready = 1'b0;
      #1;
      checkBus("abort_post", 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b1);
      checkOutput("abort_post_rdata", resp_rdata, '0);
      checkOutput("abort_post_raddr", resp_raddr, 32'h0);
      for (int i = 0; i < 3; i++) begin
         bmem_ready = 1'b1;
         tick();
         checkBus("abort_quiet", 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b1);
      end
      bmem_ready = 1'b0;
      doRead("rd_after_abort", 32'h0000_6000, 0, 1, 4'b0000, 32'h0, rand256());

      for (int n = 0; n < 24; n++) begin
         addr  = $urandom;
         al    = {addr[31:5], 5'b0};
         delta = 27'($urandom_range(1, 4095));
         line  = rand256();
         if ($urandom_range(0, 1) == 1) begin
            doWrite("rand_wr", addr, line, 4'($urandom_range(0, 15)));
         end else begin
            doRead("rand_rd", addr, $urandom_range(0, 3), $urandom_range(0, 3),
                   4'($urandom_range(0, 15)), al ^ {delta, 5'b0}, line);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
